// File: rtl/counter_clk_div.sv
// counter_clk_div: divides clk into a square wave aclk toggling every half enabled cycles, with a tick strobe on each aclk rise
module counter_clk_div #(
  parameter int          WIDTH        = 27,
  parameter int unsigned DEFAULT_HALF = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] half_in,
  output logic             aclk,
  output logic             tick,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] cnt_q, cnt_d, half_q, half_d;
  logic             aclk_q, aclk_d, tick_q, tick_d, wrap;
  always_comb begin
    wrap   = cnt_q == half_q - WIDTH'(1);
    cnt_d  = load ? '0 : en ? (wrap ? '0 : cnt_q + WIDTH'(1)) : cnt_q;
    half_d = load ? (half_in == '0 ? WIDTH'(1) : half_in) : half_q;
    aclk_d = (!load && en && wrap) ? ~aclk_q : aclk_q;
    tick_d = !load && en && wrap && !aclk_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      half_q <= WIDTH'(DEFAULT_HALF);
      aclk_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      half_q <= half_d;
      aclk_q <= aclk_d;
      tick_q <= tick_d;
    end
  end
  assign aclk  = aclk_q;
  assign tick  = tick_q;
  assign count = cnt_q;
endmodule

// File: tb/tb_counter_clk_div.sv
// tb_counter_clk_div: directed vector table plus randomized run against an arithmetic reference model
module tb_counter_clk_div;
  localparam int W = 8;
  localparam int DEF = 4;
  typedef struct {
    bit       r, e, l;
    bit [W-1:0] h;
    bit       x_aclk, x_tick;
    int       x_count;
  } vec_t;
  logic clk = 0, rst = 0, en = 0, load = 0;
  logic [W-1:0] half_in = '0;
  logic aclk, tick;
  logic [W-1:0] count;
  int checks = 0, failures = 0;
  vec_t tbl[$];
  longint n;
  bit a0, m_aclk, m_tick;
  int h;
  counter_clk_div #(.WIDTH(W), .DEFAULT_HALF(DEF)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .half_in(half_in),
    .aclk(aclk), .tick(tick), .count(count)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask
  function automatic void add(bit r, bit e, bit l, int hv, bit xa, bit xt, int xc);
    vec_t v;
    v.r = r; v.e = e; v.l = l; v.h = W'(hv);
    v.x_aclk = xa; v.x_tick = xt; v.x_count = xc;
    tbl.push_back(v);
  endfunction
  // n counts enabled cycles since the last reset/load; aclk follows from how many whole half-periods elapsed
  task automatic step(bit r, bit e, bit l, bit [W-1:0] hv);
    rst = r; en = e; load = l; half_in = hv;
    @(posedge clk);
    #1;
    if (r) begin
      n = 0; a0 = 0; h = DEF; m_tick = 0;
    end else if (l) begin
      n = 0; a0 = m_aclk; h = (hv == 0) ? 1 : int'(hv); m_tick = 0;
    end else if (e) begin
      n++;
      m_tick = (n % h == 0) && (a0 ^ bit'((n / h) % 2));
    end else m_tick = 0;
    m_aclk = a0 ^ bit'((n / h) % 2);
  endtask
  initial begin
    add(1,0,0,0, 0,0,0);
    add(1,0,0,0, 0,0,0);
    for (int i = 1; i <= 40; i++) add(0,1,0,0, bit'((i / 4) % 2), i % 8 == 4, i % 4);
    add(0,1,0,0, 0,0,1);
    add(0,1,0,0, 0,0,2);
    repeat (3) add(0,0,0,0, 0,0,2);
    add(0,1,0,0, 0,0,3);
    add(0,1,0,0, 1,1,0);
    add(0,1,0,0, 1,0,1);
    add(0,1,0,0, 1,0,2);
    add(0,1,0,0, 1,0,3);
    add(0,1,1,2, 1,0,0);
    add(0,1,0,0, 1,0,1);
    add(0,1,0,0, 0,0,0);
    add(0,1,0,0, 0,0,1);
    add(0,1,0,0, 1,1,0);
    add(0,1,0,0, 1,0,1);
    add(0,1,0,0, 0,0,0);
    add(0,1,1,0, 0,0,0);
    for (int i = 1; i <= 5; i++) add(0,1,0,0, bit'(i % 2), bit'(i % 2), 0);
    add(1,0,0,0, 0,0,0);
    for (int i = 1; i <= 7; i++) add(0,1,0,0, i >= 4, i == 4, i % 4);
    add(1,1,1,2, 0,0,0);
    for (int i = 1; i <= 4; i++) add(0,1,0,0, i == 4, i == 4, i % 4);
    add(0,0,1,3, 1,0,0);
    add(0,0,0,0, 1,0,0);
    add(0,1,0,0, 1,0,1);
    add(0,1,0,0, 1,0,2);
    add(0,1,0,0, 0,0,0);
    add(0,1,0,0, 0,0,1);
    add(0,1,0,0, 0,0,2);
    add(0,1,0,0, 1,1,0);
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].e, tbl[i].l, tbl[i].h);
      chk($sformatf("vec%0d_aclk", i), int'(aclk), int'(tbl[i].x_aclk));
      chk($sformatf("vec%0d_tick", i), int'(tick), int'(tbl[i].x_tick));
      chk($sformatf("vec%0d_count", i), int'(count), tbl[i].x_count);
    end
    step(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit r, e, l;
      r = $urandom_range(0, 199) == 0;
      l = $urandom_range(0, 39) == 0;
      e = $urandom_range(0, 3) != 0;
      step(r, e, l, W'($urandom_range(0, 9)));
      chk("rnd_aclk", int'(aclk), int'(m_aclk));
      chk("rnd_tick", int'(tick), int'(m_tick));
      chk("rnd_count", int'(count), int'(n % h));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/counter_clk_div.md
Name: counter_clk_div

Overview:
- Synchronous clock-divider counter. Derives a slow square-wave clock `aclk` from the system clock `clk` by toggling it every N enabled cycles.
- Also produces a one-cycle `tick` strobe at each rising edge of `aclk`.
- Sits at the top of the ALU board design and feeds slow-rate logic: display refresh, stepping, debounce sampling.
- `aclk` is a registered logic output, not a dedicated clock-tree resource.

Parameters:
- WIDTH, 27, bit width of the internal counter and of the half-period value.
- DEFAULT_HALF, 50000000, half-period in `clk` cycles loaded at reset. A 100 MHz `clk` gives a 1 Hz `aclk`. Must be >= 1 and < 2^WIDTH.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  synchronous active-high reset.
- en  input  1  count enable; when low, the counter and `aclk` hold their values.
- load  input  1  one-cycle request to replace the half-period with `half_in`.
- half_in  input  WIDTH  new half-period value, sampled when `load`=1.
- aclk  output  1  divided clock, 50% duty cycle, period = 2*half `clk` cycles.
- tick  output  1  one-cycle strobe asserted in the cycle `aclk` becomes 1.
- count  output  WIDTH  current internal counter value, for debug and visibility.

Behaviour:
- Single clock domain; reset is synchronous and active-high; all outputs are registered.
- Internal registers:
  - `cnt` [WIDTH], exposed as `count`.
  - `half` [WIDTH], the active half-period.
  - `aclk_r` (drives `aclk`) and `tick_r` (drives `tick`).
- Priority each cycle: `rst` > `load` > `en` > hold.
- Reset (`rst`=1 at a clk edge): `cnt`=0, `half`=DEFAULT_HALF, `aclk`=0, `tick`=0. Reset mid-period aborts the current phase; the next phase starts from zero.
- Load (`load`=1, `rst`=0):
  - `half` <= `half_in`, except `half_in`=0, which is stored as 1.
  - `cnt` <= 0, `tick` <= 0, `aclk` holds its value.
  - Load takes effect even when `en`=0.
- Count (`en`=1, no rst or load):
  - If `cnt` == `half`-1: `cnt` <= 0 and `aclk` <= ~`aclk`. `tick` <= 1 only if `aclk` is currently 0 (the rising transition); otherwise `tick` <= 0.
  - Else: `cnt` <= `cnt`+1 and `tick` <= 0.
- Hold (`en`=0): `cnt`, `half` and `aclk` keep their values; `tick` <= 0.
- `half`=1: `aclk` toggles every enabled cycle, giving `clk`/2 with `tick` every 2 cycles.
- The comparison uses the full WIDTH. `cnt` never exceeds `half`-1, so it cannot wrap.
- Timing after reset with `en`=1 held:
  - First `aclk` rise is at the half-th enabled edge.
  - `tick` is high in exactly the cycles where `aclk` is 1 for the first time in its high phase.
- Duty cycle: exactly `half` cycles high and `half` cycles low while `en` is continuously high.

Test Plan:
- DEFAULT_HALF=4, `rst` for 2 cycles, then `en`=1 for 40 cycles.
  - Required: `aclk` 0 for 4 cycles, then 1 for 4, period 8.
  - `tick` high for one cycle at each 0->1 transition (5 ticks).
  - `count` sequence 0,1,2,3,0 repeating.
- `en` toggled low for 3 cycles mid-phase at `count`=2.
  - Required: `count` stays at 2 and `aclk` is unchanged; `tick`=0 throughout.
  - The phase resumes and completes with 2 more enabled cycles.
- `load`=1 with `half_in`=2 while `aclk`=1, `count`=3.
  - Required: next cycle `count`=0 and `aclk` stays 1.
  - `aclk` then toggles every 2 cycles (period 4).
- `load` with `half_in`=0.
  - Required: behaves as half=1: `aclk` toggles every cycle, `tick` every 2nd cycle.
- `rst` asserted while `aclk`=1, `count`=3, with `load`=1 the same cycle.
  - Required: next cycle `aclk`=0, `count`=0, `tick`=0, `half`=DEFAULT_HALF (load ignored).
- `load` asserted with `en`=0, `half_in`=3.
  - Required: `count`=0 and the new half is applied.
  - After `en` rises, the first toggle occurs after 3 enabled cycles.
